// File: rtl/lsu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared constants for the load/store unit: FSM state
//               encodings, funct3 access codes and access-size decode.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // FSM state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    // Load funct3 codes
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    // Store funct3 codes
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    // Access size codes
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Decode the access size; unknown codes fall back to a full word.
    function automatic logic [1:0] access_size(input logic is_store, input logic [2:0] f3);
        logic [1:0] size;
        size = SZ_WORD;
        if (is_store) begin
            case (f3)
                SB:      size = SZ_BYTE;
                SH:      size = SZ_HALF;
                SW:      size = SZ_WORD;
                default: size = SZ_WORD;
            endcase
        end else begin
            case (f3)
                LB, LBU: size = SZ_BYTE;
                LH, LHU: size = SZ_HALF;
                LW:      size = SZ_WORD;
                default: size = SZ_WORD;
            endcase
        end
        return size;
    endfunction

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/load_formatter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : load_formatter
// Description : Combinational lane select and sign/zero extension of a
//               memory read word according to the load funct3 code.
// Revision    : 1.0 - initial release
// ============================================================================
module load_formatter
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_byte_offset,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed lane and extend it to a full word.
    always_comb begin
        w_byte = i_rdata[{i_byte_offset, 3'b000} +: 8];
        w_half = i_byte_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_funct3)
            LB:      o_data = {{24{w_byte[7]}}, w_byte};
            LH:      o_data = {{16{w_half[15]}}, w_half};
            LBU:     o_data = {24'd0, w_byte};
            LHU:     o_data = {16'd0, w_half};
            LW:      o_data = i_rdata;
            default: o_data = i_rdata;
        endcase
    end

endmodule : load_formatter
`default_nettype wire

// File: rtl/load_store_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Single-outstanding load/store unit bridging the pipeline to a
//               req/gnt/rvalid data-memory port. Stores are lane-replicated
//               with byte enables; loads are lane-selected and extended.
//               Optional macro LSU_MISALIGN_TRAP_EN: misaligned halfword/word
//               accesses trap instead of being silently aligned.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int CORE         = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    memRead,
    input  logic                    memWrite,
    input  logic [2:0]              funct3,
    input  logic [ADDRESS_BITS-1:0] address,
    input  logic [DATA_WIDTH-1:0]   store_data,
    output logic                    stall,
    output logic [DATA_WIDTH-1:0]   load_data,
    output logic                    load_valid,
    output logic                    misalign_trap,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [3:0]              mem_be,
    output logic [ADDRESS_BITS-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    report
);

    logic [1:0]              r_state;
    logic [1:0]              w_next_state;
    logic                    r_op_store;
    logic [2:0]              r_funct3;
    logic [1:0]              r_byte_off;
    logic [DATA_WIDTH-1:0]   r_load_data;
    logic [ADDRESS_BITS-1:0] r_mem_addr;
    logic [3:0]              r_mem_be;
    logic                    r_mem_we;
    logic [DATA_WIDTH-1:0]   r_mem_wdata;

    logic                    w_start;
    logic [1:0]              w_size;
    logic [1:0]              w_offset;
    logic [3:0]              w_be;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic [DATA_WIDTH-1:0]   w_fmt_data;
    logic                    w_take_trap;
    logic                    w_trapped;

    // The report hook and core index only matter to simulation-side printing.
    wire w_unused = &{1'b0, report, (CORE >= 0)};

    assign w_start = memRead | memWrite;

    // Decode the incoming request: aligned lane offset, byte enables, store data.
    always_comb begin
        w_size = access_size(memWrite, funct3);
        case (w_size)
            SZ_BYTE: w_offset = address[1:0];
            SZ_HALF: w_offset = {address[1], 1'b0};
            default: w_offset = 2'b00;
        endcase
        case (w_size)
            SZ_BYTE: begin
                w_be    = 4'b0001 << w_offset;
                w_wdata = {4{store_data[7:0]}};
            end
            SZ_HALF: begin
                w_be    = 4'b0011 << w_offset;
                w_wdata = {2{store_data[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = store_data;
            end
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_misalign;
    logic r_misalign;

    // Halfwords need a[0]=0 and words a[1:0]=0; anything else bypasses memory.
    always_comb begin
        case (w_size)
            SZ_HALF: w_misalign = address[0];
            SZ_WORD: w_misalign = |address[1:0];
            default: w_misalign = 1'b0;
        endcase
    end

    // Remember whether the transaction in flight is a trapped one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_misalign <= 1'b0;
        end else if (r_state == IDLE && w_start) begin
            r_misalign <= w_misalign;
        end
    end

    assign w_take_trap   = w_misalign;
    assign w_trapped     = r_misalign;
    assign misalign_trap = (r_state == DONE) && r_misalign;
`else
    assign w_take_trap   = 1'b0;
    assign w_trapped     = 1'b0;
    assign misalign_trap = 1'b0;
`endif

    load_formatter u_load_formatter (
        .i_funct3      (r_funct3),
        .i_byte_offset (r_byte_off),
        .i_rdata       (mem_rdata),
        .o_data        (w_fmt_data)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and per-state handshake outputs.
    always_comb begin
        w_next_state = r_state;
        stall        = 1'b0;
        mem_req      = 1'b0;
        load_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    stall        = 1'b1;
                    w_next_state = w_take_trap ? DONE : REQ;
                end
            end
            REQ: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                if (mem_gnt) begin
                    w_next_state = r_op_store ? DONE : WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (mem_rvalid) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                load_valid   = ~r_op_store & ~w_trapped;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Capture the request in IDLE and the formatted read data at the end of WAIT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_op_store  <= 1'b0;
            r_funct3    <= 3'd0;
            r_byte_off  <= 2'd0;
            r_mem_addr  <= '0;
            r_mem_be    <= 4'd0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_load_data <= '0;
        end else begin
            if (r_state == IDLE && w_start) begin
                r_op_store  <= memWrite;
                r_funct3    <= funct3;
                r_byte_off  <= w_offset;
                r_mem_addr  <= {address[ADDRESS_BITS-1:2], 2'b00};
                r_mem_be    <= w_be;
                r_mem_we    <= memWrite;
                r_mem_wdata <= w_wdata;
            end
            if (r_state == WAIT && mem_rvalid) begin
                r_load_data <= w_fmt_data;
            end
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_be    = r_mem_be;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;
    assign load_data = r_load_data;

endmodule : load_store_unit
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The module SHALL have parameter CORE, default 0, meaning the core index printed in report output.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 32, meaning the data bus width; only 32 is supported.
REQ-003 The module SHALL have parameter ADDRESS_BITS, default 32, meaning the byte address width.
REQ-004 Ports (name, direction, width, meaning):
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- memRead  in  1  load request from decode
- memWrite  in  1  store request from decode
- funct3  in  3  access size/sign
- address  in  ADDRESS_BITS  byte address from ALU
- store_data  in  32  rs2 value
- stall  out  1  hold pipeline
- load_data  out  32  formatted load result
- load_valid  out  1  one-cycle load-complete pulse
- misalign_trap  out  1  one-cycle misaligned-access pulse
- mem_req  out  1  data-memory request
- mem_we  out  1  write enable
- mem_be  out  4  byte enables
- mem_addr  out  ADDRESS_BITS  word-aligned address
- mem_wdata  out  32  lane-positioned store data
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data word
- report  in  1  print state each cycle (simulation only)

Function
REQ-005 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-006 IDLE: on memWrite or memRead, latch address, store_data, funct3, op; go to REQ; memWrite SHALL win if both are high.
REQ-007 stall SHALL be 1 in IDLE when memRead|memWrite, in REQ, and in WAIT; 0 in DONE and in idle IDLE.
REQ-008 REQ: mem_req=1 with latched fields; on mem_gnt a store SHALL go to DONE and a load to WAIT; without mem_gnt, stay in REQ with all mem_* outputs stable.
REQ-009 WAIT: mem_req=0; on mem_rvalid, register the formatted data into load_data and go to DONE.
REQ-010 DONE: load_valid=1 for loads only, for exactly one cycle; then return to IDLE unconditionally; requests sampled in DONE SHALL be ignored.
REQ-011 mem_rvalid outside WAIT and mem_gnt outside REQ SHALL be ignored.
REQ-012 Minimum stall SHALL be 2 cycles for a store and 3 cycles for a load, with gnt and rvalid each arriving in the first cycle they are eligible.
REQ-013 mem_addr SHALL be {address[ADDRESS_BITS-1:2],2'b00}.
REQ-014 funct3 SB(000): mem_be=0001<<a[1:0], byte replicated to all 4 lanes; SH(001): mem_be=0011<<(2*a[1]), half replicated to both halves; SW(010): mem_be=1111.
REQ-015 funct3 LB(000) and LH(001) SHALL sign-extend the selected lane; LBU(100) and LHU(101) SHALL zero-extend it; LW(010) SHALL pass the word through.
REQ-016 Any other funct3 SHALL be treated as LW/SW.
REQ-017 load_data SHALL hold its value until the next load completes.

Reset
REQ-018 Asserting reset SHALL immediately force state=IDLE, mem_req=0, stall=0, load_valid=0, misalign_trap=0, load_data=0, mem_be=0, mem_we=0, mem_addr=0, and mem_wdata=0, including mid-transaction; an outstanding rvalid after reset SHALL be ignored.

Configuration
REQ-019 With LSU_MISALIGN_TRAP_EN defined, a halfword access with a[0]=1 or a word access with a[1:0]!=0 SHALL issue no memory request and SHALL go IDLE->DONE with misalign_trap=1 in DONE and load_valid=0.
REQ-020 Without LSU_MISALIGN_TRAP_EN, the misaligned low address bits SHALL be cleared to the access size and misalign_trap SHALL be tied to 0.

Structure
REQ-021 Package lsu_pkg SHALL hold the FSM state encodings and the funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
REQ-022 Lane select and extension SHALL be in one sub-module, load_formatter, which is purely combinational.

Verification
REQ-023 SW 0xDEADBEEF @0x100, gnt in the first REQ cycle -> mem_be=1111, mem_addr=0x100, stall high for 2 cycles.
REQ-024 LB @0x103, rdata=0x80FFFFFF, rvalid after 2 WAIT cycles -> load_data=0xFFFFFF80, load_valid for 1 cycle.
REQ-025 LHU @0x102, rdata=0x8001_1234 -> load_data=0x00008001; SH 0xABCD @0x102 -> mem_be=1100, mem_wdata=0xABCDABCD.
REQ-026 memRead and memWrite both high -> store performed, mem_we=1.
REQ-027 reset pulsed in WAIT, then a stray rvalid -> state IDLE, load_valid stays 0.
REQ-028 With LSU_MISALIGN_TRAP_EN, LW @0x101 -> no mem_req, misalign_trap pulses once; without the macro, mem_addr=0x100, mem_be=1111.
